// File: rtl/seq_divider32_if.sv
// Start/busy/done request bundle for the sequential 32-bit divider.
// Master drives operands and start; slave returns status and results.
interface seq_divider32_if;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/seq_divider32.sv
// Multi-cycle restoring 32-bit divider (DIV/DIVU), one quotient bit per cycle.
// Signed operands are divided as magnitudes and sign-fixed in a final cycle.
module seq_divider32 #(
  parameter bit SIGNED_SUPPORT = 1'b1
) (
  input  logic           CLK,
  input  logic           nRST,
  seq_divider32_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD, DIV, FIX, DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] d_q, d_d;
  logic [31:0] dsr_q, dsr_d;
  logic [31:0] r_q, r_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic        dz_q, dz_d;

  logic [31:0] rs;
  logic        msb;
  logic [32:0] sub;
  logic        cry;
  logic        qbit;

  // Subtract-mode add/sub: sub[32] is the borrow (cryflg)
  assign msb  = r_q[31];
  assign rs   = {r_q[30:0], d_q[31]};
  assign sub  = {1'b0, rs} - {1'b0, dsr_q};
  assign cry  = sub[32];
  assign qbit = msb | ~cry;

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    dsr_d   = dsr_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d = LOAD;
          d_d     = bus.dividend;
          dsr_d   = bus.divisor;
          sgn_d   = SIGNED_SUPPORT && bus.is_signed;
          dz_d    = 1'b0;
        end
      end
      LOAD: begin
        negq_d = sgn_q & (d_q[31] ^ dsr_q[31]);
        negr_d = sgn_q & d_q[31];
        d_d    = (sgn_q && d_q[31]) ? -d_q : d_q;
        dsr_d  = (sgn_q && dsr_q[31]) ? -dsr_q : dsr_q;
        r_d    = '0;
        cnt_d  = '0;
        if (dsr_q == '0) begin
          state_d = DONE;
          quo_d   = '1;
          rem_d   = d_q;
          dz_d    = 1'b1;
        end else begin
          state_d = DIV;
        end
      end
      DIV: begin
        r_d   = qbit ? sub[31:0] : rs;
        d_d   = {d_q[30:0], qbit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        quo_d   = negq_q ? -d_q : d_q;
        rem_d   = negr_q ? -r_q : r_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      d_q     <= '0;
      dsr_q   <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      dsr_q   <= dsr_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy      = (state_q == LOAD) ||
                         (state_q == DIV)  ||
                         (state_q == FIX);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;

endmodule
